// File: rtl/imem_stream_loader_if.sv
// Bus bundle for the streaming instruction memory. It carries the PC fetch
// port, the burst-load control and the valid/ready stream from the loader FIFO.
// The master side is the SoC/testbench and the slave side is the memory.
interface imem_stream_loader_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_valid;
   logic              fetch_oob;

   logic              load_start;
   logic [ADDR_W-1:0] load_base;
   logic [CNT_W-1:0]  load_len;

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;

   logic              load_busy;
   logic              load_done;
   logic              load_err;
   logic [CNT_W-1:0]  load_cnt;

   modport master (
      output fetch_addr, load_start, load_base, load_len, s_valid, s_data,
      input  fetch_instr, fetch_valid, fetch_oob, s_ready,
             load_busy, load_done, load_err, load_cnt
   );

   modport slave (
      input  fetch_addr, load_start, load_base, load_len, s_valid, s_data,
      output fetch_instr, fetch_valid, fetch_oob, s_ready,
             load_busy, load_done, load_err, load_cnt
   );
endinterface

// File: rtl/imem_stream_loader.sv
// Parametrised instruction memory with a combinational PC fetch port and a
// burst loader fed by a valid/ready stream. After reset the array is swept
// to zero (CLEAR). From IDLE a burst is written from a base index, wrapping
// modulo DEPTH. Out-of-range fetches and loads are flagged.
module imem_stream_loader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BYTE_ADDR = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_stream_loader_if.slave   bus
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   // Byte addresses drop the two offset bits; word addresses are used as-is.
   function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
      if (BYTE_ADDR != 0) return addr >> 2;
      else                return addr;
   endfunction

   // Control state
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   // Array write request
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Address decode
   logic [ADDR_W-1:0] fetch_idx;
   logic              fetch_in_range;
   logic [ADDR_W-1:0] load_idx;
   logic              load_in_range;

   assign fetch_idx      = word_index(bus.fetch_addr);
   assign fetch_in_range = (fetch_idx < DEPTH_A);
   assign load_idx       = word_index(bus.load_base);
   assign load_in_range  = (load_idx < DEPTH_A);

   // The fetch port reads the array directly, so a write becomes visible the
   // cycle after its accepting edge. The read does not depend on the state.
   assign bus.fetch_instr = fetch_in_range ? mem[fetch_idx[IDX_W-1:0]] : '0;
   assign bus.fetch_oob   = ~fetch_in_range;

   // Status outputs all come straight from flops.
   assign bus.fetch_valid = (state_q == ST_IDLE);
   assign bus.load_busy   = (state_q != ST_IDLE);
   assign bus.s_ready     = (state_q == ST_LOAD);
   assign bus.load_done   = done_q;
   assign bus.load_err    = err_q;
   assign bus.load_cnt    = cnt_q;

   // Next-state logic for the clear sweep, load requests and burst writes.
   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      remaining_d = remaining_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = err_q;
      mem_we      = 1'b0;
      mem_waddr   = '0;
      mem_wdata   = '0;

      case (state_q)
         ST_CLEAR: begin
            // One zero word per cycle; the pointer wraps naturally since DEPTH is 2^n.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            clr_ptr_d = clr_ptr_q + IDX_W'(1);
            if (clr_ptr_q == LAST_IDX) state_d = ST_IDLE;
         end

         ST_IDLE: begin
            if (bus.load_start) begin
               if (!load_in_range) begin
                  // Rejected: flag it and report completion without any write.
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else if (bus.load_len == '0) begin
                  cnt_d  = '0;
                  err_d  = 1'b0;
                  done_d = 1'b1;
               end else begin
                  wr_ptr_d    = load_idx[IDX_W-1:0];
                  remaining_d = bus.load_len;
                  cnt_d       = '0;
                  err_d       = 1'b0;
                  state_d     = ST_LOAD;
               end
            end
         end

         ST_LOAD: begin
            if (bus.s_valid) begin
               mem_we      = 1'b1;
               mem_waddr   = wr_ptr_q;
               mem_wdata   = bus.s_data;
               wr_ptr_d    = wr_ptr_q + IDX_W'(1);
               cnt_d       = cnt_q + CNT_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               // An error is flagged only when a further word will land on a wrapped index.
               if (wr_ptr_q == LAST_IDX && remaining_q != CNT_W'(1)) err_d = 1'b1;
               if (remaining_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: state_d = ST_CLEAR;
      endcase
   end

   // Control register update; rst overrides everything and restarts the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_ptr_q   <= '0;
         wr_ptr_q    <= '0;
         remaining_q <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Array write port: either the clear sweep or an accepted stream word. No write occurs while rst is high.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
   end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: byte-addressed and word-addressed instances (DEPTH=8).
module tb_imem_stream_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_stream_loader_if #(.DATA_W(32), .DEPTH(8), .ADDR_W(32)) lb ();
   imem_stream_loader_if #(.DATA_W(32), .DEPTH(8), .ADDR_W(32)) lw ();

   imem_stream_loader #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .BYTE_ADDR(1)) u_dut (
      .clk(clk), .rst(rst), .bus(lb)
   );
   imem_stream_loader #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .BYTE_ADDR(0)) u_dut_w (
      .clk(clk), .rst(rst), .bus(lw)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] bdata [16];
   int bu_cycles;
   bit bu_rdy0, bu_fv_seen, bu_done_seen;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        oob;
   } fvec_t;
   fvec_t ftab [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_check(input string name, input bit word, input logic [31:0] addr,
                              input logic [31:0] exp_instr, input logic exp_oob);
      if (word) lw.fetch_addr = addr;
      else      lb.fetch_addr = addr;
      @(negedge clk);
      if (word) begin
         check({name, "_instr"}, lw.fetch_instr, exp_instr);
         check({name, "_oob"}, 32'(lw.fetch_oob), 32'(exp_oob));
      end else begin
         check({name, "_instr"}, lb.fetch_instr, exp_instr);
         check({name, "_oob"}, 32'(lb.fetch_oob), 32'(exp_oob));
      end
   endtask

   // Assert rst for one edge, check the reset state, then time the clear sweep and verify the array reads zero.
   task automatic clear_and_check(input string tag);
      bit done_seen;
      rst = 1'b1;
      step();
      lb.s_valid = 1'b0;
      check({tag, "_rst_fv"},    32'(lb.fetch_valid), 32'd0);
      check({tag, "_rst_busy"},  32'(lb.load_busy),   32'd1);
      check({tag, "_rst_rdy"},   32'(lb.s_ready),     32'd0);
      check({tag, "_rst_done"},  32'(lb.load_done),   32'd0);
      check({tag, "_rst_err"},   32'(lb.load_err),    32'd0);
      check({tag, "_rst_cnt"},   32'(lb.load_cnt),    32'd0);
      rst = 1'b0;
      done_seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_clr_fv%0d", tag, k + 1), 32'(lb.fetch_valid), 32'd0);
         if (lb.load_done) done_seen = 1'b1;
         step();
      end
      check({tag, "_clr_fv9"}, 32'(lb.fetch_valid), 32'd1);
      check({tag, "_clr_nodone"}, 32'(done_seen), 32'd0);
      for (int a = 0; a < 8; a++)
         fetch_check($sformatf("%s_zero%0d", tag, a), 1'b0, 32'(a * 4), 32'd0, 1'b0);
   endtask

   // Start a burst on the byte-mode instance and stream bdata[] following the valid pattern.
   task automatic run_burst(input logic [31:0] base, input logic [3:0] len,
                            input logic [15:0] vpat, input int max_cyc);
      int accepted;
      accepted = 0;
      bu_cycles = 0;
      bu_fv_seen = 1'b0;
      bu_done_seen = 1'b0;
      lb.load_base = base;
      lb.load_len = len;
      lb.load_start = 1'b1;
      step();
      lb.load_start = 1'b0;
      bu_rdy0 = lb.s_ready;
      while (accepted < int'(len) && bu_cycles < max_cyc) begin
         lb.s_valid = vpat[bu_cycles % 16];
         lb.s_data = bdata[accepted];
         if (lb.fetch_valid) bu_fv_seen = 1'b1;
         if (lb.load_done) bu_done_seen = 1'b1;
         if (lb.s_valid && lb.s_ready) accepted++;
         step();
         bu_cycles++;
      end
      lb.s_valid = 1'b0;
   endtask

   initial begin
      ftab[0]  = '{32'h0000_0000, 32'hC000_0003, 1'b0};
      ftab[1]  = '{32'h0000_0004, 32'hC000_0004, 1'b0};
      ftab[2]  = '{32'h0000_0008, 32'hB000_0001, 1'b0};
      ftab[3]  = '{32'h0000_000C, 32'hB000_0002, 1'b0};
      ftab[4]  = '{32'h0000_0010, 32'hB000_0003, 1'b0};
      ftab[5]  = '{32'h0000_0014, 32'h0000_0000, 1'b0};
      ftab[6]  = '{32'h0000_0018, 32'hC000_0001, 1'b0};
      ftab[7]  = '{32'h0000_001C, 32'hC000_0002, 1'b0};
      ftab[8]  = '{32'h0000_0003, 32'hC000_0003, 1'b0};
      ftab[9]  = '{32'h0000_001F, 32'hC000_0002, 1'b0};
      ftab[10] = '{32'h0000_0020, 32'h0000_0000, 1'b1};
      ftab[11] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

      lb.fetch_addr = '0; lb.load_start = 1'b0; lb.load_base = '0; lb.load_len = '0;
      lb.s_valid = 1'b0;  lb.s_data = '0;
      lw.fetch_addr = '0; lw.load_start = 1'b0; lw.load_base = '0; lw.load_len = '0;
      lw.s_valid = 1'b0;  lw.s_data = '0;

      // Power-up reset and clear
      clear_and_check("init");

      // Fill the array with garbage, then reset and expect it swept back to zero
      for (int i = 0; i < 8; i++) bdata[i] = 32'hDEAD_0000 + 32'(i);
      run_burst(32'h0, 4'd8, 16'hFFFF, 40);
      check("garbage_cycles", 32'(bu_cycles), 32'd8);
      fetch_check("garbage_rd7", 1'b0, 32'h1C, 32'hDEAD_0007, 1'b0);
      clear_and_check("reclear");

      // Byte-addressed burst with continuous valid
      bdata[0] = 32'hA000_0001; bdata[1] = 32'hA000_0002; bdata[2] = 32'hA000_0003;
      run_burst(32'h08, 4'd3, 16'hFFFF, 40);
      check("burst_rdy_next", 32'(bu_rdy0), 32'd1);
      check("burst_cycles", 32'(bu_cycles), 32'd3);
      check("burst_early_done", 32'(bu_done_seen), 32'd0);
      check("burst_done", 32'(lb.load_done), 32'd1);
      check("burst_busy", 32'(lb.load_busy), 32'd0);
      check("burst_cnt", 32'(lb.load_cnt), 32'd3);
      check("burst_err", 32'(lb.load_err), 32'd0);
      step();
      check("burst_done_1cyc", 32'(lb.load_done), 32'd0);
      fetch_check("burst_rd08", 1'b0, 32'h08, 32'hA000_0001, 1'b0);
      fetch_check("burst_rd0c", 1'b0, 32'h0C, 32'hA000_0002, 1'b0);
      fetch_check("burst_rd10", 1'b0, 32'h10, 32'hA000_0003, 1'b0);

      // Same burst with s_valid toggling 1,0,0,1,0,1
      bdata[0] = 32'hB000_0001; bdata[1] = 32'hB000_0002; bdata[2] = 32'hB000_0003;
      run_burst(32'h08, 4'd3, 16'h0029, 40);
      check("stall_cycles", 32'(bu_cycles), 32'd6);
      check("stall_fv_low", 32'(bu_fv_seen), 32'd0);
      check("stall_early_done", 32'(bu_done_seen), 32'd0);
      check("stall_done", 32'(lb.load_done), 32'd1);
      check("stall_cnt", 32'(lb.load_cnt), 32'd3);
      fetch_check("stall_rd04", 1'b0, 32'h04, 32'h0, 1'b0);
      fetch_check("stall_rd14", 1'b0, 32'h14, 32'h0, 1'b0);

      // Burst wrapping from idx 7 back to idx 0
      for (int i = 0; i < 4; i++) bdata[i] = 32'hC000_0001 + 32'(i);
      run_burst(32'h18, 4'd4, 16'hFFFF, 40);
      check("wrap_cycles", 32'(bu_cycles), 32'd4);
      check("wrap_done", 32'(lb.load_done), 32'd1);
      check("wrap_err", 32'(lb.load_err), 32'd1);
      check("wrap_cnt", 32'(lb.load_cnt), 32'd4);

      // Out-of-range base: error, done pulse, no LOAD entry, no write
      lb.load_base = 32'h40; lb.load_len = 4'd2; lb.load_start = 1'b1;
      step();
      lb.load_start = 1'b0;
      check("oob_done", 32'(lb.load_done), 32'd1);
      check("oob_err", 32'(lb.load_err), 32'd1);
      check("oob_busy", 32'(lb.load_busy), 32'd0);
      check("oob_rdy", 32'(lb.s_ready), 32'd0);
      step();
      check("oob_done_1cyc", 32'(lb.load_done), 32'd0);
      check("oob_err_sticky", 32'(lb.load_err), 32'd1);

      // Array contents after all bursts, including out-of-range fetches
      for (int i = 0; i < 12; i++)
         fetch_check($sformatf("tab%0d", i), 1'b0, ftab[i].addr, ftab[i].instr, ftab[i].oob);

      // Zero-length burst: done pulse, error and count cleared
      lb.load_base = 32'h0; lb.load_len = 4'd0; lb.load_start = 1'b1;
      step();
      lb.load_start = 1'b0;
      check("zlen_done", 32'(lb.load_done), 32'd1);
      check("zlen_err", 32'(lb.load_err), 32'd0);
      check("zlen_cnt", 32'(lb.load_cnt), 32'd0);
      check("zlen_busy", 32'(lb.load_busy), 32'd0);
      step();
      check("zlen_done_1cyc", 32'(lb.load_done), 32'd0);

      // Reset after two of four words: burst aborted and array re-cleared
      lb.load_base = 32'h0; lb.load_len = 4'd4; lb.load_start = 1'b1;
      step();
      lb.load_start = 1'b0;
      lb.s_valid = 1'b1; lb.s_data = 32'hE000_0001;
      step();
      lb.s_data = 32'hE000_0002;
      step();
      check("midrst_busy", 32'(lb.load_busy), 32'd1);
      lb.s_data = 32'hE000_0003;
      clear_and_check("midrst");

      // Word-addressed instance: base 5, two words
      lw.load_base = 32'd5; lw.load_len = 4'd2; lw.load_start = 1'b1;
      step();
      lw.load_start = 1'b0;
      lw.s_valid = 1'b1; lw.s_data = 32'hF000_0001;
      step();
      lw.s_data = 32'hF000_0002;
      step();
      lw.s_valid = 1'b0;
      check("word_done", 32'(lw.load_done), 32'd1);
      check("word_cnt", 32'(lw.load_cnt), 32'd2);
      fetch_check("word_rd5", 1'b1, 32'd5, 32'hF000_0001, 1'b0);
      fetch_check("word_rd6", 1'b1, 32'd6, 32'hF000_0002, 1'b0);
      fetch_check("word_rd4", 1'b1, 32'd4, 32'h0, 1'b0);
      fetch_check("word_rd7", 1'b1, 32'd7, 32'h0, 1'b0);
      fetch_check("word_rd8", 1'b1, 32'd8, 32'h0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/imem_stream_loader.md
# imem_stream_loader

Parametrised instruction memory for the Fibonacci microprocessor. It is the next generation of the 8-word instruction store. It has a combinational fetch port for the PC and a valid/ready stream port fed by the loader FIFO. A load state machine writes a programmed burst of words from a base address. After reset it clears the array autonomously, and it flags out-of-range fetches and loads.

## Interface
- DATA_W, 32: instruction/data word width.
- DEPTH, 8: number of words; power of two, ≥2.
- ADDR_W, 32: width of fetch/load addresses.
- BYTE_ADDR, 1: 1 = addresses are byte addresses, word index = addr[ADDR_W-1:2]; 0 = addresses are word indices.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_addr  in  ADDR_W  PC fetch address.
- fetch_instr  out  DATA_W  instruction at fetch_addr; combinational.
- fetch_valid  out  1  1 when the array is stable for fetching (state IDLE).
- fetch_oob  out  1  combinational; fetch index ≥ DEPTH.
- load_start  in  1  one-cycle request to begin a burst.
- load_base  in  ADDR_W  start address of the burst, sampled with load_start.
- load_len  in  $clog2(DEPTH)+1  number of words in the burst, sampled with load_start.
- s_valid  in  1  stream word valid (from the FIFO).
- s_data  in  DATA_W  stream word.
- s_ready  out  1  block accepts a word this cycle.
- load_busy  out  1  state ≠ IDLE.
- load_done  out  1  one-cycle pulse when a burst completes.
- load_err  out  1  sticky; cleared only by rst or by an accepted load_start.
- load_cnt  out  $clog2(DEPTH)+1  words written in the current or last burst.

## Operation
- Word index: idx = BYTE_ADDR ? addr >> 2 : addr. The index is in range when idx < DEPTH.
- Fetch:
  - fetch_instr = mem[idx] when in range; otherwise all-zero, with fetch_oob = 1.
  - The read is independent of state. fetch_valid gates its use.
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Entered on rst.
  - Writes 0 to mem[clr_ptr] each cycle while rst is low, clr_ptr = 0 … DEPTH-1.
  - Goes to IDLE after the write to DEPTH-1.
  - s_ready = 0. load_start is ignored.
- IDLE, on load_start:
  - base index out of range: load_err ← 1, load_done pulses, stay IDLE, no write.
  - load_len = 0: load_done pulses, load_cnt ← 0, stay IDLE.
  - otherwise: wr_ptr ← base index, remaining ← load_len, load_cnt ← 0, load_err ← 0, go to LOAD.
- LOAD:
  - s_ready = 1.
  - Each cycle with s_valid & s_ready: mem[wr_ptr] ← s_data, load_cnt++, remaining--.
  - wr_ptr advances modulo DEPTH. Wrap from DEPTH-1 to 0 sets load_err; the write still occurs.
  - When the last word is accepted (remaining = 1): go to IDLE and pulse load_done the following cycle.
  - s_valid low stalls; there is no timeout.
- load_start while in LOAD or CLEAR is ignored; no error.
- load_len > DEPTH is accepted. Words wrap and overwrite earlier ones, and load_err is set.

## Timing
- Reset values (cycle after rst sampled high, and while rst stays high):
  - state = CLEAR, clr_ptr = 0.
  - s_ready = 0, fetch_valid = 0, load_busy = 1.
  - load_done = 0, load_err = 0, load_cnt = 0.
- rst has priority over every input. Asserting rst mid-LOAD aborts the burst: no load_done, and the array is re-cleared.
- CLEAR takes exactly DEPTH cycles after rst deasserts. fetch_valid rises on cycle DEPTH+1.
- The write is visible on fetch_instr in the cycle after the accepting edge. A same-cycle fetch of the written address returns the old value.
- load_start → s_ready high next cycle.
- N-word burst with continuous s_valid: accepting cycles 1…N; load_done high and load_busy low on cycle N+1.
- Error and zero-length cases on load_start: load_done high on the next cycle, no LOAD entry.
- load_done is exactly one cycle wide. load_err holds until the next accepted load_start or rst.
- fetch_oob and fetch_instr are purely combinational from fetch_addr and the array.

## Test plan
- Reset clear:
  - Stimulus: preload garbage, pulse rst 1 cycle, DEPTH=8.
  - Required: fetch_valid=0 for 8 cycles then 1; every address 0x00…0x1C reads 0.
- Byte-addressed burst:
  - Stimulus: load_base=0x08, load_len=3, stream 0xA0000001/2/3 with continuous valid.
  - Required: load_done on cycle 4; fetch 0x08/0x0C/0x10 return those words; load_cnt=3; load_err=0.
- Stall and backpressure:
  - Stimulus: same burst with s_valid toggling 1,0,0,1,0,1.
  - Required: exactly 3 writes; load_done one cycle after the third acceptance; fetch_valid=0 throughout LOAD.
- Wrap and error:
  - Stimulus: load_base=0x18 (idx 6), load_len=4.
  - Required: writes to idx 6,7,0,1; load_err=1 after the wrap; load_done pulses.
- Out-of-range and zero-length:
  - Stimulus: fetch 0x20 → fetch_instr=0, fetch_oob=1. load_start with base 0x40 → load_err=1, no write. load_len=0 → load_done pulse, load_err=0.
- Mid-load reset and word mode:
  - Stimulus: rst after 2 of 4 words.
  - Required: no load_done, array re-cleared.
  - Stimulus: BYTE_ADDR=0 instance, base=5, len=2.
  - Required: idx 5,6 written.
